// File: rtl/tank_motion_responder_pkg.sv
// Shared types and constants for the tank motion responder and its step calculator.
package tank_motion_responder_pkg;

    localparam int COORD_W      = 11;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    // Up > Down > Left > Right; caller guarantees at least one key is held
    function automatic dir_t key_priority(input logic up, input logic down,
                                          input logic left, input logic right);
        dir_t d;
        if (up)
            d = DIR_UP;
        else if (down)
            d = DIR_DOWN;
        else if (left)
            d = DIR_LEFT;
        else if (right)
            d = DIR_RIGHT;
        else
            d = DIR_UP;
        return d;
    endfunction

    function automatic logic [COORD_W-1:0] clamp_hi(input logic [COORD_W:0] v,
                                                    input logic [COORD_W:0] lim);
        logic [COORD_W:0] r;
        if (v > lim)
            r = lim;
        else
            r = v;
        return r[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/tank_motion_responder_if.sv
// Keypad / collision-checker / drawing-object signals of the tank motion responder.
interface tank_motion_responder_if;
    import tank_motion_responder_pkg::*;

    logic               startOfFrame;
    logic               keyUp;
    logic               keyDown;
    logic               keyLeft;
    logic               keyRight;
    logic               collision;
    logic [COORD_W-1:0] tankTopLeftX;
    logic [COORD_W-1:0] tankTopLeftY;
    dir_t               tankDir;
    logic               blocked;
    logic [7:0]         bumpCount;

    modport master (
        output startOfFrame, keyUp, keyDown, keyLeft, keyRight, collision,
        input  tankTopLeftX, tankTopLeftY, tankDir, blocked, bumpCount
    );

    modport slave (
        input  startOfFrame, keyUp, keyDown, keyLeft, keyRight, collision,
        output tankTopLeftX, tankTopLeftY, tankDir, blocked, bumpCount
    );

endinterface

// File: rtl/tank_motion_responder_step_calc.sv
// Combinational single-step move: shifts one axis by SPEED, widened by one bit
// so underflow and overflow are detected and clamped instead of wrapping.
module tank_motion_responder_step_calc
    import tank_motion_responder_pkg::*;
#(
    parameter int SPEED = 2,
    parameter int MAX_X = 608,
    parameter int MAX_Y = 448
) (
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  dir_t               dir,
    output logic [COORD_W-1:0] next_x,
    output logic [COORD_W-1:0] next_y
);

    localparam int               CW1     = COORD_W + 1;
    localparam logic [COORD_W:0] SPEED_W = CW1'(SPEED);
    localparam logic [COORD_W:0] MAX_X_W = CW1'(MAX_X);
    localparam logic [COORD_W:0] MAX_Y_W = CW1'(MAX_Y);

    logic [COORD_W:0] x_ext_s;
    logic [COORD_W:0] y_ext_s;

    // Move along the facing axis; the other axis is only held inside its bound
    always_comb begin
        x_ext_s = {1'b0, pos_x};
        y_ext_s = {1'b0, pos_y};
        next_x  = clamp_hi(x_ext_s, MAX_X_W);
        next_y  = clamp_hi(y_ext_s, MAX_Y_W);
        case (dir)
            DIR_UP: begin
                if (y_ext_s < SPEED_W)
                    next_y = {COORD_W{1'b0}};
                else
                    next_y = clamp_hi(y_ext_s - SPEED_W, MAX_Y_W);
            end
            DIR_DOWN:  next_y = clamp_hi(y_ext_s + SPEED_W, MAX_Y_W);
            DIR_LEFT: begin
                if (x_ext_s < SPEED_W)
                    next_x = {COORD_W{1'b0}};
                else
                    next_x = clamp_hi(x_ext_s - SPEED_W, MAX_X_W);
            end
            DIR_RIGHT: next_x = clamp_hi(x_ext_s + SPEED_W, MAX_X_W);
            default: begin
                next_x = pos_x;
                next_y = pos_y;
            end
        endcase
    end

endmodule

// File: rtl/tank_motion_responder.sv
// Per-frame tank mover: steps from the keys, waits for the collision checker to
// settle, and reverts the step if the tank now overlaps a brick.
module tank_motion_responder
    import tank_motion_responder_pkg::*;
#(
    parameter int SCREEN_W      = DEF_SCREEN_W,
    parameter int SCREEN_H      = DEF_SCREEN_H,
    parameter int TANK_W        = 32,
    parameter int TANK_H        = 32,
    parameter int SPEED         = 2,
    parameter int INIT_X        = 304,
    parameter int INIT_Y        = 416,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    resetN,
    tank_motion_responder_if.slave  bus
);

    localparam logic [COORD_W-1:0] INIT_X_C    = COORD_W'(INIT_X);
    localparam logic [COORD_W-1:0] INIT_Y_C    = COORD_W'(INIT_Y);
    localparam logic [3:0]         SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t             state_r;
    logic [3:0]         settle_cnt_r;
    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;
    logic [COORD_W-1:0] saved_x_r;
    logic [COORD_W-1:0] saved_y_r;
    dir_t               dir_r;
    dir_t               pend_dir_r;
    logic               blocked_r;
    logic [7:0]         bump_r;

    logic               any_key_s;
    logic [COORD_W-1:0] next_x_s;
    logic [COORD_W-1:0] next_y_s;

    assign any_key_s = bus.keyUp | bus.keyDown | bus.keyLeft | bus.keyRight;

    tank_motion_responder_step_calc #(
        .SPEED (SPEED),
        .MAX_X (SCREEN_W - TANK_W),
        .MAX_Y (SCREEN_H - TANK_H)
    ) u_step_calc (
        .pos_x  (x_r),
        .pos_y  (y_r),
        .dir    (pend_dir_r),
        .next_x (next_x_s),
        .next_y (next_y_s)
    );

    // Frame FSM: the direction is latched at the IDLE decision so later key changes are ignored
    always_ff @(posedge clk) begin
        if (resetN) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= 4'd0;
            x_r          <= INIT_X_C;
            y_r          <= INIT_Y_C;
            saved_x_r    <= INIT_X_C;
            saved_y_r    <= INIT_Y_C;
            dir_r        <= DIR_UP;
            pend_dir_r   <= DIR_UP;
            blocked_r    <= 1'b0;
            bump_r       <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.startOfFrame && any_key_s) begin
                        saved_x_r  <= x_r;
                        saved_y_r  <= y_r;
                        pend_dir_r <= key_priority(bus.keyUp, bus.keyDown,
                                                   bus.keyLeft, bus.keyRight);
                        state_r    <= ST_STEP;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_STEP: begin
                    x_r          <= next_x_s;
                    y_r          <= next_y_s;
                    dir_r        <= pend_dir_r;
                    settle_cnt_r <= 4'd0;
                    state_r      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_r      <= ST_CHECK;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (bus.collision) begin
                        x_r       <= saved_x_r;
                        y_r       <= saved_y_r;
                        blocked_r <= 1'b1;
                        if (bump_r != 8'hFF)
                            bump_r <= bump_r + 8'd1;
                        else
                            bump_r <= bump_r;
                    end else begin
                        blocked_r <= 1'b0;
                    end
                    state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign bus.tankTopLeftX = x_r;
    assign bus.tankTopLeftY = y_r;
    assign bus.tankDir      = dir_r;
    assign bus.blocked      = blocked_r;
    assign bus.bumpCount    = bump_r;

endmodule

// File: doc/tank_motion_responder.md
Name: tank_motion_responder

Overview:
- Consumer end of the tank/brick collision interface: owns the tank's top-left position, drives it to the collision checker, and reacts to the registered collision flag it returns.
- Once per video frame it applies one movement step from the player keys, waits for the collision result, and reverts the step if the tank now overlaps a brick.
- Sits between the keypad decoder, the collision checker and the tank drawing object.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- TANK_W, 32, tank width in pixels
- TANK_H, 32, tank height in pixels
- SPEED, 2, pixels moved per frame step
- INIT_X, 304, reset X position
- INIT_Y, 416, reset Y position
- SETTLE_CYCLES, 3, clocks between the position update and collision sampling; legal range 2..15

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous active-high reset (despite the name)
- startOfFrame  in  1  one-cycle pulse, once per frame
- keyUp  in  1  level, move request
- keyDown  in  1  level, move request
- keyLeft  in  1  level, move request
- keyRight  in  1  level, move request
- collision  in  1  registered overlap flag from the collision checker
- tankTopLeftX  out  11  tank X, unsigned
- tankTopLeftY  out  11  tank Y, unsigned
- tankDir  out  2  facing: 0 up, 1 down, 2 left, 3 right
- blocked  out  1  high if the last step was reverted
- bumpCount  out  8  count of reverted steps, saturating

Behaviour:
- Reset, sampled on the clk edge while resetN=1:
  - tankTopLeftX=INIT_X, tankTopLeftY=INIT_Y
  - tankDir=0, blocked=0, bumpCount=0
  - state=IDLE, settle counter=0, saved position=INIT
  - Reset mid-operation aborts any pending step with no revert.
- State machine: IDLE, STEP, SETTLE, CHECK.
- IDLE:
  - On startOfFrame=1 with any key held, latch the current X/Y into the saved registers and go to STEP.
  - With no key held, stay in IDLE and leave blocked unchanged.
- STEP, one cycle:
  - Key priority is Up > Down > Left > Right; tankDir is set to the winning key.
  - New coordinate = old ± SPEED, computed 12-bit wide and then clamped.
  - X clamps to 0..SCREEN_W-TANK_W (608); Y clamps to 0..SCREEN_H-TANK_H (448).
  - An underflow (old < SPEED moving up or left) clamps to 0, with no wrap.
  - tankDir updates even when the clamp leaves the position unchanged.
  - Clear the settle counter and go to SETTLE.
- SETTLE:
  - Count SETTLE_CYCLES clocks and ignore collision throughout, covering the checker's registered latency plus pipeline.
  - When the count is reached, go to CHECK.
- CHECK, one cycle, sample collision:
  - If 1: restore the saved X/Y on the next edge, set blocked=1, and increment bumpCount, saturating at 255.
  - If 0: keep the new X/Y and set blocked=0.
  - Always return to IDLE.
- startOfFrame outside IDLE is ignored; it is not queued.
- Key changes after the IDLE→STEP decision are ignored until the next frame.
- Timing:
  - Position changes at most once per frame, plus one possible revert.
  - Latency from startOfFrame to the new position is 2 clocks.
  - Latency from startOfFrame to the reverted position is SETTLE_CYCLES+3 clocks.
- The tank starting inside a brick (collision already 1 before a step) still causes a revert of that step. This behaviour is required, and it keeps the tank stationary.

Decomposition:
- Shared package (e.g. battle_pkg):
  - direction enum dir_t {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}
  - the coordinate width constant COORD_W=11
  - the screen dimension constants
- One natural sub-module, tank_step_calc: combinational; takes position, direction, SPEED and bounds, and returns the clamped next position.
- The state machine, settle counter, saved registers and bump counter stay in the top module.

Test Plan:
- Reset, then a single startOfFrame with keyRight and collision=0 → X=306, Y=416, tankDir=3, blocked=0 two clocks after the pulse.
- Position X=2, keyLeft held for 2 frames, collision=0 → X=0 after the first frame and X=0 after the second frame, with no wrap to 2046.
- keyUp and keyRight held together → Y decreases by 2, X unchanged, tankDir=0.
- keyDown at Y=416 with collision forced to 1 from the STEP+2 cycle → Y goes 416→418→416, blocked=1, bumpCount=1.
- A glitch on collision during SETTLE that is 0 at CHECK → no revert, blocked=0; a second startOfFrame pulse mid-SETTLE is ignored.
- 300 consecutive blocked frames → bumpCount saturates at 255; resetN asserted in SETTLE → next clock X/Y=INIT, state IDLE, bumpCount=0.
